grade_display_sequencer: RTL and testbench
==========================================

GRADE_DISPLAY_SEQUENCER -- requirements
Module: grade_display_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, grade FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter DWELL, default 4, clock cycles each display phase lasts (>=1).
REQ-003 SHALL have port clk_2  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port grade_in  input  4  student grade, valid range 0-9.
REQ-006 SHALL have port push  input  1  request to enqueue grade_in this cycle.
REQ-007 SHALL have port seg  output  8  display pattern, bit0=a … bit6=g, bit7=decimal point.
REQ-008 SHALL have port full, empty  output  1 each  FIFO status, registered.
REQ-009 SHALL have port err  output  1  one-cycle pulse when a push is rejected.
REQ-010 SHALL have port cnt_a, cnt_f, cnt_p  output  4 each  counts of classified A/F/P grades.

Function
REQ-011 Push accepted iff push=1, full=0 and grade_in<=9; accepted entry is written at that edge.
REQ-012 Push with full=1 or grade_in>9: entry dropped, err=1 the next cycle only, no other state change.
REQ-013 full/empty use the pre-edge occupancy: a pop in the same cycle does not make a push with full=1 succeed; push and pop both occurring with 0<count<DEPTH leaves count unchanged.
REQ-014 FSM states: IDLE, SHOW_GRADE, SHOW_CLASS.
REQ-015 IDLE: seg=8'h40 ('-'); if empty=0, pop head into grade_q and go to SHOW_GRADE.
REQ-016 SHOW_GRADE: seg = digit of grade_q (0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F), bit7=0; after DWELL cycles go to SHOW_CLASS.
REQ-017 SHOW_CLASS: seg = class of grade_q with bit7=1: grade>=7 'A' 8'hF7; 4<=grade<7 'F' 8'hF1; grade<4 'P' 8'hF3; lasts DWELL cycles.
REQ-018 Classification counter increments once, on the transition edge into SHOW_CLASS; saturates at 15.
REQ-019 End of SHOW_CLASS: if empty=0, pop and go directly to SHOW_GRADE (no IDLE cycle); else go to IDLE.
REQ-020 Latency: push into empty FIFO while IDLE at edge t -> SHOW_GRADE seg visible after edge t+1.
REQ-021 Dwell counter width $clog2(DWELL+1); reloads on every phase entry; no phase ever lasts other than exactly DWELL cycles.
REQ-022 seg, full, empty, err, cnt_* are all registered outputs.

Reset
REQ-023 rst_n=0 asynchronously forces: state IDLE, FIFO pointers/count 0, seg=8'h40, full=0, empty=1, err=0, cnt_a=cnt_f=cnt_p=0, grade_q=0.
REQ-024 Reset mid-display discards the grade in progress and all queued grades; its class is not counted unless already counted.
REQ-025 After rst_n deasserts, first push accepted on the first rising edge with rst_n=1.

Structure
REQ-026 Shared package SHALL hold the state enum, the 8-bit seg constants for digits 0-9, 'A', 'F', 'P', '-', and class thresholds 4 and 7.
REQ-027 One combinational sub-module grade_seg_decoder (grade, show_class) -> seg SHALL provide the REQ-016/REQ-017 encoding; FIFO and FSM stay in the top module.

Verification
REQ-028 Reset, push 8 -> after edge+1 seg=7F for 4 cycles, then F7 for 4 cycles, then 40; cnt_a=1.
REQ-029 Push 3, 5, 9 back-to-back -> seg sequence 4F,F3,6D,F1,6F,F7 with 4 cycles each and no '-' gap; cnt_p=1, cnt_f=1, cnt_a=1.
REQ-030 Fill FIFO with 4 pushes while showing a grade, 5th push -> err=1 one cycle, full=1, 5th grade never displayed.
REQ-031 Push grade_in=12 -> err=1, empty stays 1, seg stays 40.
REQ-032 Push 16 grades of 9 -> cnt_a saturates at 15.
REQ-033 Assert rst_n=0 mid-SHOW_GRADE with 2 queued -> immediate seg=40, empty=1, counters 0.

Source files
------------

// File: rtl/grade_display_sequencer_pkg.sv
// Shared types and constants for the grade display sequencer: FSM states,
// grade classes, seven-segment patterns and classification thresholds.
package grade_display_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHOW_GRADE = 2'd1,
        SHOW_CLASS = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_A = 2'd0,
        CLS_F = 2'd1,
        CLS_P = 2'd2
    } grade_class_t;

    // Segment patterns, bit0=a .. bit6=g, bit7=decimal point
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };
    localparam logic [7:0] SEG_A    = 8'hF7;
    localparam logic [7:0] SEG_F    = 8'hF1;
    localparam logic [7:0] SEG_P    = 8'hF3;
    localparam logic [7:0] SEG_DASH = 8'h40;

    // Grades at or above CLASS_A_MIN are 'A', at or above CLASS_F_MIN are 'F'
    localparam logic [3:0] CLASS_F_MIN = 4'd4;
    localparam logic [3:0] CLASS_A_MIN = 4'd7;
    localparam logic [3:0] GRADE_MAX   = 4'd9;

    function automatic grade_class_t classify(input logic [3:0] grade);
        if (grade >= CLASS_A_MIN)
            return CLS_A;
        else if (grade >= CLASS_F_MIN)
            return CLS_F;
        else
            return CLS_P;
    endfunction

endpackage

// File: rtl/grade_seg_decoder.sv
// Combinational grade-to-segment decoder: shows either the digit of the
// grade or its class letter with the decimal point lit.
module grade_seg_decoder
    import grade_display_sequencer_pkg::*;
(
    input  logic [3:0] grade,
    input  logic       show_class,
    output logic [7:0] seg
);

    // Class letter when requested, otherwise the digit; out-of-range shows '-'
    always_comb begin
        seg = SEG_DASH;
        if (show_class) begin
            case (classify(grade))
                CLS_A:   seg = SEG_A;
                CLS_F:   seg = SEG_F;
                default: seg = SEG_P;
            endcase
        end else if (grade <= GRADE_MAX) begin
            seg = SEG_DIGIT[grade];
        end
    end

endmodule

// File: rtl/grade_display_sequencer.sv
// Grade display sequencer: queues student grades in a small FIFO and shows
// each one as a digit for DWELL cycles, then as its class letter for DWELL
// cycles, keeping saturating per-class counts.
module grade_display_sequencer
    import grade_display_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DWELL = 4
) (
    input  logic       clk_2,
    input  logic       rst_n,
    input  logic [3:0] grade_in,
    input  logic       push,
    output logic [7:0] seg,
    output logic       full,
    output logic       empty,
    output logic       err,
    output logic [3:0] cnt_a,
    output logic [3:0] cnt_f,
    output logic [3:0] cnt_p
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int DWELL_W = $clog2(DWELL + 1);

    // FIFO storage and status
    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             err_reg;
    logic             push_ok;
    logic             pop;

    // Display FSM
    state_t             state_reg;
    state_t             state_next;
    logic [3:0]         grade_q_reg;
    logic [3:0]         grade_q_next;
    logic [DWELL_W-1:0] dwell_reg;
    logic [DWELL_W-1:0] dwell_next;
    logic               enter_class;
    logic [7:0]         seg_reg;
    logic [7:0]         seg_next;
    logic [7:0]         dec_seg;

    // Classification counters
    logic [2:0]  class_hit;
    logic [11:0] cnt_bus;

    // Status flags are registered, so a push is judged on pre-edge occupancy
    assign push_ok    = push && !full_reg && (grade_in <= GRADE_MAX);
    assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop);

    // Storage write; no reset needed since pointers define what is valid
    always_ff @(posedge clk_2) begin
        if (push_ok)
            mem[wr_ptr_reg] <= grade_in;
    end

    // FIFO pointers, occupancy, status flags and reject pulse
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            err_reg    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
            err_reg   <= push && !push_ok;
        end
    end

    // Next-state logic: pops land directly in grade_q, phases reload the dwell
    always_comb begin
        state_next   = state_reg;
        grade_q_next = grade_q_reg;
        dwell_next   = dwell_reg;
        pop          = 1'b0;
        enter_class  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty_reg) begin
                    pop          = 1'b1;
                    grade_q_next = mem[rd_ptr_reg];
                    dwell_next   = DWELL_W'(DWELL);
                    state_next   = SHOW_GRADE;
                end
            end
            SHOW_GRADE: begin
                if (dwell_reg == DWELL_W'(1)) begin
                    enter_class = 1'b1;
                    dwell_next  = DWELL_W'(DWELL);
                    state_next  = SHOW_CLASS;
                end else begin
                    dwell_next = dwell_reg - DWELL_W'(1);
                end
            end
            SHOW_CLASS: begin
                if (dwell_reg == DWELL_W'(1)) begin
                    dwell_next = DWELL_W'(DWELL);
                    if (!empty_reg) begin
                        // Chain straight into the next grade with no '-' gap
                        pop          = 1'b1;
                        grade_q_next = mem[rd_ptr_reg];
                        state_next   = SHOW_GRADE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    dwell_next = dwell_reg - DWELL_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decode from next-state values so the pattern is visible right after the edge
    grade_seg_decoder u_decoder (
        .grade      (grade_q_next),
        .show_class (state_next == SHOW_CLASS),
        .seg        (dec_seg)
    );

    // Idle shows a dash, otherwise whatever the decoder produced
    always_comb begin
        seg_next = dec_seg;
        if (state_next == IDLE)
            seg_next = SEG_DASH;
    end

    // FSM and display registers
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            grade_q_reg <= '0;
            dwell_reg   <= DWELL_W'(DWELL);
            seg_reg     <= SEG_DASH;
        end else begin
            state_reg   <= state_next;
            grade_q_reg <= grade_q_next;
            dwell_reg   <= dwell_next;
            seg_reg     <= seg_next;
        end
    end

    // One-hot class strobe on the edge that enters SHOW_CLASS
    always_comb begin
        class_hit = 3'b000;
        if (enter_class) begin
            case (classify(grade_q_reg))
                CLS_A:   class_hit[0] = 1'b1;
                CLS_F:   class_hit[1] = 1'b1;
                default: class_hit[2] = 1'b1;
            endcase
        end
    end

    // Saturating counters: index 0=A, 1=F, 2=P
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [3:0] cnt_reg;

            // Count up on the class strobe, holding at 15
            always_ff @(posedge clk_2 or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg <= 4'd0;
                else if (class_hit[gi] && (cnt_reg != 4'hF))
                    cnt_reg <= cnt_reg + 4'd1;
            end

            assign cnt_bus[gi*4 +: 4] = cnt_reg;
        end
    endgenerate

    assign seg   = seg_reg;
    assign full  = full_reg;
    assign empty = empty_reg;
    assign err   = err_reg;
    assign cnt_a = cnt_bus[3:0];
    assign cnt_f = cnt_bus[7:4];
    assign cnt_p = cnt_bus[11:8];

endmodule

// File: tb/tb_grade_display_sequencer.sv
// Directed bench for grade_display_sequencer. A per-cycle queue of expected
// segment patterns is filled whenever an accepted grade is pushed and drained
// one entry per clock as the display advances.
module tb_grade_display_sequencer;

    localparam int DWELL = 4;

    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic [3:0] grade_in;
    logic       push;
    logic [7:0] seg;
    logic       full;
    logic       empty;
    logic       err;
    logic [3:0] cnt_a;
    logic [3:0] cnt_f;
    logic [3:0] cnt_p;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seg_q [$];
    logic [7:0] digit_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                   8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    always #5 clk_2 = ~clk_2;

    grade_display_sequencer #(.DEPTH(4), .DWELL(DWELL)) dut (
        .clk_2    (clk_2),
        .rst_n    (rst_n),
        .grade_in (grade_in),
        .push     (push),
        .seg      (seg),
        .full     (full),
        .empty    (empty),
        .err      (err),
        .cnt_a    (cnt_a),
        .cnt_f    (cnt_f),
        .cnt_p    (cnt_p)
    );

    function automatic logic [7:0] class_seg(input logic [3:0] g);
        if (g >= 4'd7)      return 8'hF7;
        else if (g >= 4'd4) return 8'hF1;
        else                return 8'hF3;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic enqueue(input logic [3:0] g);
        for (int i = 0; i < DWELL; i++) seg_q.push_back(digit_tab[g]);
        for (int i = 0; i < DWELL; i++) seg_q.push_back(class_seg(g));
    endtask

    // One clock: drive, take the edge, then check seg and err against the model
    task automatic step(input logic do_push, input logic [3:0] g, input logic exp_acc);
        logic [7:0] exp_seg;
        grade_in = g;
        push     = do_push;
        @(posedge clk_2);
        #1;
        push = 1'b0;
        exp_seg = (seg_q.size() > 0) ? seg_q.pop_front() : 8'h40;
        chk("seg", seg, exp_seg);
        chk("err", {7'd0, err}, {7'd0, do_push && !exp_acc});
        if (do_push && exp_acc)
            enqueue(g);
        $display("step push=%0b grade=%0d seg=%h err=%0b full=%0b empty=%0b cnt_a=%0d cnt_f=%0d cnt_p=%0d",
                 do_push, g, seg, err, full, empty, cnt_a, cnt_f, cnt_p);
    endtask

    task automatic drain();
        while (seg_q.size() > 0) step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic chk_cnts(input string tag, input logic [3:0] a, input logic [3:0] f, input logic [3:0] p);
        chk({tag, "_cnt_a"}, {4'd0, cnt_a}, {4'd0, a});
        chk({tag, "_cnt_f"}, {4'd0, cnt_f}, {4'd0, f});
        chk({tag, "_cnt_p"}, {4'd0, cnt_p}, {4'd0, p});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        push     = 1'b0;
        grade_in = 4'd0;
        repeat (2) @(posedge clk_2);
        #1;
        // Reset state
        chk("rst_seg", seg, 8'h40);
        chk("rst_full", {7'd0, full}, 8'd0);
        chk("rst_empty", {7'd0, empty}, 8'd1);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk_cnts("rst", 4'd0, 4'd0, 4'd0);
        rst_n = 1'b1;

        // Single grade 8: first visible one edge after the push
        step(1'b1, 4'd8, 1'b1);
        chk("t1_empty_after_push", {7'd0, empty}, 8'd0);
        step(1'b0, 4'd0, 1'b0);
        chk("t1_empty_after_pop", {7'd0, empty}, 8'd1);
        drain();
        chk_cnts("t1", 4'd1, 4'd0, 4'd0);

        // Back-to-back 3, 5, 9 with no dash between them
        step(1'b1, 4'd3, 1'b1);
        step(1'b1, 4'd5, 1'b1);
        step(1'b1, 4'd9, 1'b1);
        drain();
        chk_cnts("t2", 4'd2, 4'd1, 4'd1);

        // Fill the FIFO behind grade 1, then overflow
        step(1'b1, 4'd1, 1'b1);
        step(1'b1, 4'd2, 1'b1);
        step(1'b1, 4'd3, 1'b1);
        step(1'b1, 4'd4, 1'b1);
        step(1'b1, 4'd5, 1'b1);
        chk("t3_full", {7'd0, full}, 8'd1);
        step(1'b1, 4'd6, 1'b0);
        chk("t3_full_after_reject", {7'd0, full}, 8'd1);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        // Pop happens on this same edge, but full was set before it
        step(1'b1, 4'd7, 1'b0);
        chk("t3_full_after_pop", {7'd0, full}, 8'd0);
        drain();
        chk_cnts("t3", 4'd2, 4'd3, 4'd4);

        // Out-of-range grade is rejected
        step(1'b1, 4'd12, 1'b0);
        chk("t4_empty", {7'd0, empty}, 8'd1);
        step(1'b0, 4'd0, 1'b0);
        chk("t4_empty_later", {7'd0, empty}, 8'd1);

        // Reset mid-SHOW_GRADE with two grades queued
        step(1'b1, 4'd2, 1'b1);
        step(1'b1, 4'd3, 1'b1);
        step(1'b1, 4'd4, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_seg", seg, 8'h40);
        chk("t5_empty", {7'd0, empty}, 8'd1);
        chk("t5_full", {7'd0, full}, 8'd0);
        chk_cnts("t5", 4'd0, 4'd0, 4'd0);
        seg_q.delete();
        #2 rst_n = 1'b1;

        // Sixteen grades of 9: A counter saturates at 15
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'd9, 1'b1);
            while (seg_q.size() > 0) step(1'b0, 4'd0, 1'b0);
            chk("t6_cnt_a", {4'd0, cnt_a}, (i < 15) ? 8'(i + 1) : 8'd15);
        end
        step(1'b0, 4'd0, 1'b0);
        chk_cnts("t6", 4'd15, 4'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
